// File: rtl/vga_scanout_if.sv
// vga_scanout_if: frame-buffer read port plus VGA pin bundle.
//   rd_address : {y, x} presented to the buffer's asynchronous read port
//   rd_data    : 4:4:4 RGB returned by the buffer
//   red/green/blue, hsync, vsync, active, frame_start : display pins
// master = scanout engine, slave = buffer/display side.
interface vga_scanout_if #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned X_WIDTH    = 10,
  parameter int unsigned Y_WIDTH    = 10
);
  logic [X_WIDTH+Y_WIDTH-1:0] rd_address;
  logic [DATA_WIDTH-1:0]      rd_data;
  logic [3:0]                 red;
  logic [3:0]                 green;
  logic [3:0]                 blue;
  logic                       hsync;
  logic                       vsync;
  logic                       active;
  logic                       frame_start;

  modport master (
    output rd_address,
    input  rd_data,
    output red, green, blue, hsync, vsync, active, frame_start
  );

  modport slave (
    input  rd_address,
    output rd_data,
    input  red, green, blue, hsync, vsync, active, frame_start
  );
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout: raster timing generator and pixel output register.
// Ports:
//   clock    : system clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : vga_scanout_if.master (buffer read port + display pins)
// A clock divider produces pixel_tick; h/v counters walk the raster on each
// tick. The counters address the buffer combinationally, and the returned
// pixel plus syncs are registered on the tick, giving one pixel of latency.
module vga_scanout #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned X_WIDTH    = 10,
  parameter int unsigned Y_WIDTH    = 10,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33
) (
  input  logic          clock,
  input  logic          reset_n,
  vga_scanout_if.master bus
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  // Counter widths hold H_TOTAL / V_TOTAL so the sync-end bound never truncates.
  localparam int unsigned HC_W     = $clog2(H_TOTAL + 1);
  localparam int unsigned VC_W     = $clog2(V_TOTAL + 1);
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [DIV_W-1:0]      div_q, div_d;
  logic [HC_W-1:0]       h_q, h_d;
  logic [VC_W-1:0]       v_q, v_d;
  logic [DATA_WIDTH-1:0] rgb_q, rgb_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic                  active_q, active_d;
  logic                  start_q, start_d;
  logic                  frame_start_q, frame_start_d;

  logic pixel_tick;
  logic vis;

  assign pixel_tick = (div_q == DIV_W'(CLK_DIV - 1));
  assign vis        = (h_q < HC_W'(H_VISIBLE)) && (v_q < VC_W'(V_VISIBLE));

  // Buffer address follows the counters; blanking reads address 0.
  assign bus.rd_address = vis ? {Y_WIDTH'(v_q), X_WIDTH'(h_q)} : '0;

  // Next-state: divider, raster counters and the output pixel register.
  always_comb begin
    div_d         = div_q;
    h_d           = h_q;
    v_d           = v_q;
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    start_d       = 1'b0;
    frame_start_d = start_q;

    if (pixel_tick) begin
      div_d = '0;
      if (h_q == HC_W'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == VC_W'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
      rgb_d    = vis ? bus.rd_data : '0;
      active_d = vis;
      hsync_d  = !((h_q >= HC_W'(HS_START)) && (h_q < HC_W'(HS_END)));
      vsync_d  = !((v_q >= VC_W'(VS_START)) && (v_q < VC_W'(VS_END)));
      // Marks the tick that registers (0,0); frame_start follows one clock later.
      start_d  = (h_q == '0) && (v_q == '0);
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      start_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      start_q       <= start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.red         = rgb_q[11:8];
  assign bus.green       = rgb_q[7:4];
  assign bus.blue        = rgb_q[3:0];
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.active      = active_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: three scanout builds (small raster /4, small raster /1,
// full 640x480 /4) run side by side. Each build's expected pin values for
// every clock are derived from the clock count since reset release and the
// raster geometry, pushed into a queue, and popped/compared by a monitor.
// The buffer model returns rd_address[11:0] ^ key, with key changed only
// while reset is held.
module tb_vga_scanout;

  typedef struct packed {
    logic [31:0] kk;
    logic [19:0] addr;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        act;
    logic        fs;
  } exp_t;

  logic clock;
  int   vectors     = 0;
  int   miscompares = 0;
  int   fail_prints = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int g, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL inst%0d %s k=%0d: got %0h, expected %0h", g, name, k, act, exp);
      end
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int D  = (g == 1) ? 1 : 4;
    localparam int HV = (g == 0) ? 16 : (g == 1) ? 10 : 640;
    localparam int HF = (g == 0) ? 2  : (g == 1) ? 3  : 16;
    localparam int HS = (g == 0) ? 3  : (g == 1) ? 4  : 96;
    localparam int HB = (g == 0) ? 2  : (g == 1) ? 5  : 48;
    localparam int VV = (g == 0) ? 8  : (g == 1) ? 6  : 480;
    localparam int VF = (g == 0) ? 1  : (g == 1) ? 2  : 10;
    localparam int VS = (g == 0) ? 2  : (g == 1) ? 1  : 2;
    localparam int VB = (g == 0) ? 1  : (g == 1) ? 3  : 33;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int NPIX = HT * VT;
    localparam int L1 = (g == 0) ? 2500 : (g == 1) ? 700 : 8000;
    localparam int L2 = (g == 0) ? 1500 : (g == 1) ? 500 : 3500;

    logic        rst_drv;
    logic [11:0] key;
    int          k;
    bit          started;
    bit          done_g;
    exp_t        q[$];

    vga_scanout_if #(.DATA_WIDTH(12), .X_WIDTH(10), .Y_WIDTH(10)) bus ();

    vga_scanout #(
      .DATA_WIDTH(12), .X_WIDTH(10), .Y_WIDTH(10), .CLK_DIV(D),
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
      .clock  (clock),
      .reset_n(rst_drv),
      .bus    (bus)
    );

    assign bus.rd_data = bus.rd_address[11:0] ^ key;

    // Pin values after kk clocks since the last reset clock.
    function automatic exp_t model(input int kk, input logic [11:0] kkey);
      exp_t e;
      int c, cx, cy, m, mx, my;
      bit v;
      e.kk = 32'(kk);
      c  = (kk / D) % NPIX;
      cx = c % HT;
      cy = c / HT;
      e.addr = (cx < HV && cy < VV) ? 20'(cy * 1024 + cx) : 20'd0;
      if (kk < D) begin
        e.rgb = 12'h000;
        e.hs  = 1'b1;
        e.vs  = 1'b1;
        e.act = 1'b0;
      end else begin
        m  = (kk / D - 1) % NPIX;
        mx = m % HT;
        my = m / HT;
        v  = (mx < HV) && (my < VV);
        e.rgb = v ? (12'(my * 1024 + mx) ^ kkey) : 12'h000;
        e.act = v;
        e.hs  = !((mx >= HV + HF) && (mx < HV + HF + HS));
        e.vs  = !((my >= VV + VF) && (my < VV + VF + VS));
      end
      e.fs = (kk >= D + 1) && (((kk - 1) % D) == 0) && ((((kk - 1) / D - 1) % NPIX) == 0);
      return e;
    endfunction

    task automatic step();
      @(posedge clock);
      if (!rst_drv) k = 0;
      else          k++;
      #1;
      q.push_back(model(k, key));
      started = 1'b1;
    endtask

    // Stimulus: power-on reset, long run, one-clock mid-frame reset, then
    // random resets with a fresh buffer pattern each time.
    initial begin
      rst_drv = 1'b0;
      key     = 12'h000;
      k       = 0;
      started = 1'b0;
      done_g  = 1'b0;
      repeat (10) step();
      rst_drv = 1'b1;
      repeat (L1) step();
      rst_drv = 1'b0;
      step();
      rst_drv = 1'b1;
      repeat (L2) step();
      for (int r = 0; r < 3; r++) begin
        rst_drv = 1'b0;
        key     = 12'($urandom);
        repeat ($urandom_range(3, 1)) step();
        rst_drv = 1'b1;
        repeat ($urandom_range(L2, L2 / 2)) step();
      end
      done_g = 1'b1;
    end

    // Monitor: one expected record per clock, compared mid-cycle.
    always @(negedge clock) begin
      exp_t e;
      if (started) begin
        if (q.size() == 0) begin
          if (!done_g) begin
            vectors++;
            miscompares++;
            $display("FAIL inst%0d scoreboard_underflow: got empty queue, expected a record", g);
          end
        end else begin
          e = q.pop_front();
          check("rd_address",  g, int'(e.kk), 32'(bus.rd_address), 32'(e.addr));
          check("rgb",         g, int'(e.kk), 32'({bus.red, bus.green, bus.blue}), 32'(e.rgb));
          check("hsync",       g, int'(e.kk), 32'(bus.hsync), 32'(e.hs));
          check("vsync",       g, int'(e.kk), 32'(bus.vsync), 32'(e.vs));
          check("active",      g, int'(e.kk), 32'(bus.active), 32'(e.act));
          check("frame_start", g, int'(e.kk), 32'(bus.frame_start), 32'(e.fs));
        end
      end
    end
  end

  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int c = 0; c < 60000 && !all_done; c++) begin
      @(posedge clock);
      all_done = cfg[0].done_g && cfg[1].done_g && cfg[2].done_g;
    end
    if (!all_done) begin
      vectors++;
      miscompares++;
      $display("FAIL run_timeout: got unfinished stimulus, expected completion within 60000 clocks");
    end
    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Display-side consumer of the frame buffer. Generates 640x480@60 VGA raster timing from the system clock, presents the current pixel coordinate to the buffer's asynchronous read port as `{y, x}`, and registers the returned 12-bit RGB together with hsync/vsync so the pins see aligned colour and sync. Blanking intervals force black.

## Interface
- `DATA_WIDTH`, 12: pixel width, 4:4:4 RGB with R in [11:8], G in [7:4], B in [3:0].
- `X_WIDTH`, 10: x coordinate width.
- `Y_WIDTH`, 10: y coordinate width.
- `CLK_DIV`, 4: system clocks per pixel (4 gives 25 MHz from 100 MHz); legal range 1..16.
- `H_VISIBLE` 640, `H_FRONT` 16, `H_SYNC` 96, `H_BACK` 48: horizontal timing in pixels.
- `V_VISIBLE` 480, `V_FRONT` 10, `V_SYNC` 2, `V_BACK` 33: vertical timing in lines.

Ports:
- `clock` in 1: system clock; all state changes on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `rd_address` out X_WIDTH+Y_WIDTH: buffer read address `{y, x}`.
- `rd_data` in DATA_WIDTH: buffer read data, combinational from `rd_address`.
- `red`, `green`, `blue` out 4 each: registered colour.
- `hsync`, `vsync` out 1: registered syncs, active-low.
- `active` out 1: registered; high while the output pixel is visible.
- `frame_start` out 1: one-clock pulse when the outputs present pixel (0,0).

## Operation
- Divider `div` counts 0..CLK_DIV-1 and wraps. `pixel_tick` = (div == CLK_DIV-1). With CLK_DIV = 1, `pixel_tick` is high on every clock.
- Counters `h` (0..H_TOTAL-1) and `v` (0..V_TOTAL-1) advance only on `pixel_tick`. H_TOTAL = 800 and V_TOTAL = 525 with defaults.
  - `h` wraps to 0 at H_TOTAL-1.
  - `v` increments when `h` wraps and itself wraps to 0 at V_TOTAL-1.
- `vis` = (h < H_VISIBLE) && (v < V_VISIBLE).
- `rd_address` is combinational from the counters:
  - `{v[Y_WIDTH-1:0], h[X_WIDTH-1:0]}` when `vis`.
  - All zeros during blanking.
- Output register, updated on `pixel_tick` only:
  - `{red, green, blue}` <= `vis ? rd_data : 0`.
  - `active` <= `vis`.
  - `hsync` <= !(h >= H_VISIBLE+H_FRONT && h < H_VISIBLE+H_FRONT+H_SYNC).
  - `vsync` <= !(v >= V_VISIBLE+V_FRONT && v < V_VISIBLE+V_FRONT+V_SYNC).
- `frame_start` is high for exactly one clock: the clock after the `pixel_tick` that registers h=0, v=0. It is low otherwise.
- Counter and sync widths are sized internally to hold H_TOTAL-1 and V_TOTAL-1. Only the low X_WIDTH/Y_WIDTH bits reach `rd_address`.
- The block never writes the buffer and has no back-pressure. The write side may update any address at any time. Tearing is acceptable.

## Timing
- Reset values, held while `reset_n` = 0:
  - `div` = 0, `h` = 0, `v` = 0, `rd_address` = 0.
  - `red`/`green`/`blue` = 0, `hsync` = 1, `vsync` = 1, `active` = 0, `frame_start` = 0.
- Reset mid-frame: the next clock restores all reset values. Scan restarts at (0,0) after deassertion with no partial-line output.
- First `pixel_tick` after deassertion: clock CLK_DIV (1-based).
  - That tick registers pixel (0,0).
  - `frame_start` pulses one clock later.
- Latency: colour, sync and `active` lag the counters by exactly one pixel period. `rd_data` must be stable by the end of the pixel period in which `rd_address` is presented.
- Outputs change only on the clock following a `pixel_tick`, so each output value is held for CLK_DIV clocks.
- Line period: H_TOTAL × CLK_DIV clocks (3200 with defaults). Frame period: 525 × 3200 = 1,680,000 clocks.
- Wrap at (H_TOTAL-1, V_TOTAL-1): the next tick returns to (0,0). No extra or missing pixel.

## Test plan
- Reset/startup: hold `reset_n` = 0 for 10 clocks, then release.
  - During reset: all outputs at their reset values.
  - `frame_start` pulse exactly 5 clocks after release (CLK_DIV = 4).
- Line timing: drive `rd_data` = 12'hFFF and measure one line.
  - `hsync` low for 96×4 = 384 clocks per 3200-clock line.
  - Falling edge occurs 656 pixels after `active` rises.
  - `active` high for 640 pixels.
- Frame timing: measure one frame.
  - `vsync` low for exactly 2 lines (6400 clocks), starting 490 lines after `frame_start`.
  - `frame_start` period is 1,680,000 clocks.
- Address/data alignment: buffer model returns `rd_data` = `rd_address[11:0]`.
  - Output pixel at (x=5, y=3) shows `{red, green, blue}` = 12'hC05, i.e. low 12 bits of {3,5}.
  - Blanking pixels show 0, and `rd_address` = 0 there.
- Mid-frame reset: assert `reset_n` = 0 for 1 clock at (x=300, y=200).
  - Next clock: outputs at reset values.
  - Scan resumes at (0,0), with `frame_start` CLK_DIV+1 clocks after release.
- CLK_DIV = 1 build: `pixel_tick` high every clock and line period is 800 clocks; repeat the alignment check.
